// File: rtl/fifo_sched_pkg.sv
// Shared types and default sizing for the FIFO pop scheduler.
// Optional feature macro: POP_COUNT_EN (per-FIFO pop counters with readout port).
package fifo_sched_pkg;

    localparam int N_FIFO_DEF = 5;
    localparam int IDX_W_DEF  = 3;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/fifo_pop_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester searching ptr+1, ptr+2, ...
// with wrap from N_FIFO-1 back to 0. The last requester checked is ptr itself,
// so a lone requester is re-granted every cycle.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int N_FIFO = N_FIFO_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic [N_FIFO-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [N_FIFO-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    int               j;
    logic [IDX_W-1:0] k;

    // Rotating priority search starting just after the last grant
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        k         = '0;
        for (int i = 1; i <= N_FIFO; i++) begin
            j = (int'(ptr) + i) % N_FIFO;
            k = IDX_W'(j);
            if (!any && req[k]) begin
                any       = 1'b1;
                grant_idx = k;
                grant     = '0;
                grant[k]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_pop_scheduler.sv
// Round-robin pop scheduler for the egress FIFO bank.
// At most one pop per cycle, gated combinationally by downstream almost-full.
// Optional feature macro: POP_COUNT_EN adds per-FIFO pop counters readable while IDLE.
module fifo_pop_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int N_FIFO = N_FIFO_DEF,
    parameter int IDX_W  = IDX_W_DEF
`ifdef POP_COUNT_EN
    ,parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic [N_FIFO-1:0] fifo_empty,
    input  logic              out_afull,
    output logic [N_FIFO-1:0] fifo_pop,
    output logic              pop_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              IDLE
`ifdef POP_COUNT_EN
    ,input  logic             req,
    input  logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic [CNT_W-1:0]  data_out
`endif
);

    sched_state_e      state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [N_FIFO-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic              do_pop;

    rr_arbiter #(.N_FIFO(N_FIFO), .IDX_W(IDX_W)) u_arb (
        .req       (~fifo_empty),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Pop only in ACTIVE; almost-full kills the strobe in the same cycle
    assign do_pop   = (state == ST_ACTIVE) && !out_afull && arb_any;
    assign fifo_pop = do_pop ? arb_grant : '0;

    // Next-state: enable low forces INIT from anywhere
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_INIT;
        end else begin
            case (state)
                ST_INIT:   state_nxt = ST_IDLE;
                ST_IDLE:   if (arb_any) state_nxt = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (out_afull)     state_nxt = ST_PAUSE;
                    else if (!arb_any) state_nxt = ST_IDLE;
                end
                ST_PAUSE:  if (!out_afull) state_nxt = arb_any ? ST_ACTIVE : ST_IDLE;
                default:   state_nxt = ST_INIT;
            endcase
        end
    end

    // State and round-robin pointer; pointer starts at the last index so FIFO 0 wins first
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= ST_INIT;
            rr_ptr <= IDX_W'(N_FIFO - 1);
        end else begin
            state <= state_nxt;
            if (do_pop) rr_ptr <= arb_idx;
        end
    end

    // Registered pop report lines up with FIFO read data; IDLE tracks the state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_valid <= 1'b0;
            grant_idx <= '0;
            IDLE      <= 1'b0;
        end else begin
            pop_valid <= do_pop;
            if (do_pop) grant_idx <= arb_idx;
            IDLE      <= (state_nxt == ST_IDLE);
        end
    end

`ifdef POP_COUNT_EN
    logic [N_FIFO-1:0][CNT_W-1:0] cnt;
    logic                         idx_ok;

    assign idx_ok = ({1'b0, idx} < (IDX_W + 1)'(N_FIFO));

    // Per-FIFO pop counters, wrap naturally at 2^CNT_W; retained across enable drops
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (do_pop) begin
            cnt[arb_idx] <= cnt[arb_idx] + CNT_W'(1);
        end
    end

    // Counter readout only honoured while IDLE; data_out holds between reads
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else if (req && IDLE && idx_ok) begin
            valid    <= 1'b1;
            data_out <= cnt[idx];
        end else begin
            valid    <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pop_scheduler.sv
// Self-checking bench for fifo_pop_scheduler: directed table, reset/counter
// sequences, then randomized traffic against a behavioural model.
module tb_fifo_pop_scheduler;

    localparam int NF = 5;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          enable;
    logic [NF-1:0] fifo_empty;
    logic          out_afull;
    logic [NF-1:0] fifo_pop;
    logic          pop_valid;
    logic [2:0]    grant_idx;
    logic          IDLE;
`ifdef POP_COUNT_EN
    logic          req;
    logic [2:0]    idx;
    logic          valid;
    logic [4:0]    data_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_pop_scheduler dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .out_afull  (out_afull),
        .fifo_pop   (fifo_pop),
        .pop_valid  (pop_valid),
        .grant_idx  (grant_idx),
        .IDLE       (IDLE)
`ifdef POP_COUNT_EN
        ,.req       (req),
        .idx        (idx),
        .valid      (valid),
        .data_out   (data_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_L    = 1'b0;
        enable     = 1'b1;
        fifo_empty = '1;
        out_afull  = 1'b0;
`ifdef POP_COUNT_EN
        req = 1'b0;
        idx = '0;
`endif
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    // Directed vectors: inputs for a cycle and what must be seen in that cycle
    typedef struct {
        logic          en;
        logic [NF-1:0] empty;
        logic          af;
        logic [NF-1:0] pop;
        logic          pv;
        logic [2:0]    gi;
        logic          idle;
    } vec_t;
    vec_t tbl[22];

    // Behavioural model: mode 0=init 1=idle 2=active 3=pause, last = last granted FIFO
    int   m_mode, m_last, m_gi;
    logic m_pv, m_idle;
    int   m_cnt[NF];
    logic m_valid;
    int   m_data;

    function automatic int pick(input logic [NF-1:0] e, input int last);
        for (int k = 1; k <= NF; k++) begin
            if (!e[(last + k) % NF]) return (last + k) % NF;
        end
        return -1;
    endfunction

    function automatic logic [NF-1:0] model_pop();
        int g;
        logic [NF-1:0] r;
        r = '0;
        g = pick(fifo_empty, m_last);
        if (m_mode == 2 && !out_afull && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_last = NF - 1; m_gi = 0; m_pv = 0; m_idle = 0;
        m_valid = 0; m_data = 0;
        for (int i = 0; i < NF; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        int  g;
        bit  popped, any_ne;
        g      = pick(fifo_empty, m_last);
        any_ne = (g >= 0);
        popped = (m_mode == 2 && !out_afull && any_ne);
`ifdef POP_COUNT_EN
        if (req && m_idle && idx < NF) begin
            m_valid = 1; m_data = m_cnt[idx];
        end else begin
            m_valid = 0;
        end
`endif
        m_pv = popped;
        if (popped) begin
            m_gi = g; m_last = g; m_cnt[g] = (m_cnt[g] + 1) % 32;
        end
        if (!enable) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1) m_mode = any_ne ? 2 : 1;
        else if (m_mode == 2) m_mode = out_afull ? 3 : (any_ne ? 2 : 1);
        else if (!out_afull) m_mode = any_ne ? 2 : 1;
        m_idle = (m_mode == 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npop;

        tbl[0]  = '{1'b1, 5'b11111, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 5'b11111, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b1};
        tbl[2]  = '{1'b1, 5'b11111, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b1};
        tbl[3]  = '{1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b1};
        tbl[4]  = '{1'b1, 5'b00000, 1'b0, 5'b00001, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{1'b1, 5'b00000, 1'b0, 5'b00010, 1'b1, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 5'b00000, 1'b0, 5'b00100, 1'b1, 3'd1, 1'b0};
        tbl[7]  = '{1'b1, 5'b00000, 1'b0, 5'b01000, 1'b1, 3'd2, 1'b0};
        tbl[8]  = '{1'b1, 5'b00000, 1'b0, 5'b10000, 1'b1, 3'd3, 1'b0};
        tbl[9]  = '{1'b1, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd4, 1'b0};
        tbl[10] = '{1'b1, 5'b00000, 1'b0, 5'b00010, 1'b1, 3'd0, 1'b0};
        tbl[11] = '{1'b1, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd1, 1'b0};
        tbl[12] = '{1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
        tbl[13] = '{1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{1'b1, 5'b00000, 1'b0, 5'b00100, 1'b0, 3'd0, 1'b0};
        tbl[15] = '{1'b1, 5'b10111, 1'b0, 5'b01000, 1'b1, 3'd2, 1'b0};
        tbl[16] = '{1'b1, 5'b10111, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b0};
        tbl[17] = '{1'b1, 5'b10111, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b0};
        tbl[18] = '{1'b1, 5'b11111, 1'b0, 5'b00000, 1'b1, 3'd3, 1'b0};
        tbl[19] = '{1'b1, 5'b11111, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b1};
        tbl[20] = '{1'b0, 5'b11111, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b1};
        tbl[21] = '{1'b0, 5'b11111, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};

        // Reset values, checked while reset is held
        reset_L = 1'b0; enable = 1'b0; fifo_empty = '1; out_afull = 1'b0;
`ifdef POP_COUNT_EN
        req = 1'b0; idx = '0;
`endif
        #3;
        chk("rst_pop", fifo_pop, 0);
        chk("rst_pv", pop_valid, 0);
        chk("rst_gi", grant_idx, 0);
        chk("rst_idle", IDLE, 0);
`ifdef POP_COUNT_EN
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);
`endif

        // Directed table: idle bring-up, RR sweep, afull pause, lone FIFO, enable drop
        do_reset();
        for (int i = 0; i < 22; i++) begin
            enable = tbl[i].en; fifo_empty = tbl[i].empty; out_afull = tbl[i].af;
            #1;
            chk($sformatf("tbl%0d_pop", i), fifo_pop, tbl[i].pop);
            chk($sformatf("tbl%0d_pv", i), pop_valid, tbl[i].pv);
            if (tbl[i].pv) chk($sformatf("tbl%0d_gi", i), grant_idx, tbl[i].gi);
            chk($sformatf("tbl%0d_idle", i), IDLE, tbl[i].idle);
            @(negedge clk);
        end

        // Reset mid-burst aborts immediately; restart grants FIFO 0 first
        enable = 1'b1; fifo_empty = '0; out_afull = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("burst_pop_live", (fifo_pop != 0), 1);
        #2 reset_L = 1'b0;
        #1;
        chk("midrst_pop", fifo_pop, 0);
        chk("midrst_pv", pop_valid, 0);
        chk("midrst_idle", IDLE, 0);
        @(negedge clk); reset_L = 1'b1; #1;
        chk("restart_init_pop", fifo_pop, 0);
        @(negedge clk); #1;
        chk("restart_idle", IDLE, 1);
        @(negedge clk); #1;
        chk("restart_first", fifo_pop, 5'b00001);

`ifdef POP_COUNT_EN
        // Counter wrap: 33 pops of FIFO 2 leave 1 in a 5-bit counter
        do_reset();
        fifo_empty = 5'b11011;
        npop = 0;
        for (int c = 0; c < 60 && npop < 33; c++) begin
            #1;
            if (fifo_pop == 5'b00100) npop++;
            @(negedge clk);
        end
        chk("cnt_pops_seen", npop, 33);
        fifo_empty = '1;
        @(negedge clk); #1;
        chk("cnt_idle", IDLE, 1);
        req = 1'b1; idx = 3'd2;
        @(negedge clk); #1;
        chk("cnt_valid", valid, 1);
        chk("cnt_data", data_out, 1);
        idx = 3'd5;
        @(negedge clk); #1;
        chk("cnt_badidx_valid", valid, 0);
        chk("cnt_hold_data", data_out, 1);
        req = 1'b0;
`endif

        // Randomized traffic against the behavioural model
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            enable     = ($urandom_range(0, 29) != 0);
            fifo_empty = ($urandom_range(0, 3) == 0) ? 5'b11111 : NF'($urandom);
            out_afull  = ($urandom_range(0, 4) == 0);
`ifdef POP_COUNT_EN
            req = ($urandom_range(0, 2) == 0);
            idx = 3'($urandom_range(0, 7));
`endif
            #1;
            chk("rnd_pop", fifo_pop, model_pop());
            chk("rnd_pv", pop_valid, m_pv);
            if (m_pv) chk("rnd_gi", grant_idx, m_gi);
            chk("rnd_idle", IDLE, m_idle);
`ifdef POP_COUNT_EN
            chk("rnd_valid", valid, m_valid);
            chk("rnd_data", data_out, m_data);
`endif
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
